// File: rtl/snn_host_pkg.sv
`default_nettype none
// ============================================================================
// Module   : snn_host_pkg
// Purpose  : Shared dimensions, packet widths, sequencer state encoding and
//            address / popcount helpers for the SNN host sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package snn_host_pkg;

    localparam int IFM_DIM = 25;                    // ifmap rows and row width
    localparam int FLT_DIM = 5;                     // filter side
    localparam int FLT_N   = FLT_DIM * FLT_DIM;     // number of filter weights
    localparam int OFM_DIM = IFM_DIM - FLT_DIM + 1; // output rows / row width
    localparam int W_BITS  = 8;                     // weight width
    localparam int TS_W    = 4;                     // timestep index width
    localparam int IDX_W   = 5;                     // row / weight index width
    localparam int ADDR_W  = 8;                     // ROM / result RAM address
    localparam int CNT_W   = 16;                    // spike counter width

    localparam int FL_PKT_W = IDX_W + W_BITS;
    localparam int IF_PKT_W = TS_W + IDX_W + IFM_DIM;
    localparam int SR_PKT_W = TS_W + 1;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LDST   = 4'd1,
        S_FLT_RD = 4'd2,
        S_FLT_TX = 4'd3,
        S_IFM_RD = 4'd4,
        S_IFM_TX = 4'd5,
        S_WLD    = 4'd6,
        S_SRST   = 4'd7,
        S_COLL   = 4'd8,
        S_DONE   = 4'd9
    } state_t;

    // ifmap ROM address of a row within a timestep
    function automatic logic [ADDR_W-1:0] ifm_addr(input logic [TS_W-1:0] ts,
                                                   input logic [IDX_W-1:0] row);
        logic [ADDR_W-1:0] base;
        base = ADDR_W'(ts) * ADDR_W'(IFM_DIM);
        return base + ADDR_W'(row);
    endfunction

    // result RAM address of an output row within a timestep
    function automatic logic [ADDR_W-1:0] res_addr(input logic [TS_W-1:0] ts,
                                                   input logic [IDX_W-1:0] row);
        logic [ADDR_W-1:0] base;
        base = ADDR_W'(ts) * ADDR_W'(OFM_DIM);
        return base + ADDR_W'(row);
    endfunction

    function automatic logic [IDX_W-1:0] popcount(input logic [OFM_DIM-1:0] d);
        logic [IDX_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < OFM_DIM; i++) begin
            cnt = cnt + IDX_W'(d[i]);
        end
        return cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/snn_vr_hold.sv
`default_nettype none
// ============================================================================
// Module   : snn_vr_hold
// Purpose  : Single valid/ready holding register. A load captures the payload
//            and raises valid; valid falls on the edge where valid && ready.
// Ports    : clk, rst (async, active-high)
//            i_load, i_data  - capture new payload (only while o_valid = 0)
//            i_ready         - downstream ready
//            o_valid, o_data - registered valid and stable payload
// Revision : 1.0 - initial release
// ============================================================================
module snn_vr_hold #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/snn_host_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : snn_host_sequencer
// Purpose  : Host-side driver for the SNN NoC. Streams the 25 filter weights
//            once per run, then for each timestep streams 25 ifmap rows, waits
//            for load_done, issues start_r and collects output-spike rows into
//            the result RAM until done_r.
// Ports    : i_start/i_layer - run request; o_busy/o_done/o_err status
//            flt/ifm ROM read ports (1-cycle latency)
//            ls, fl, if, sr  - outbound valid/ready streams
//            ld, osp, dr     - inbound valid/ready streams
//            res_*           - result RAM write port
//            o_spike_cnt     - total accepted output spikes
// Config   : SNN_SPIKE_COUNT_EN - enables the saturating spike counter;
//            when undefined o_spike_cnt is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module snn_host_sequencer
    import snn_host_pkg::*;
#(
    parameter int NUM_TS = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic                i_layer,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err,
    output logic [IDX_W-1:0]    o_flt_raddr,
    input  logic [W_BITS-1:0]   i_flt_rdata,
    output logic [ADDR_W-1:0]   o_ifm_raddr,
    input  logic [IFM_DIM-1:0]  i_ifm_rdata,
    output logic                o_ls_v,
    input  logic                i_ls_r,
    output logic                o_fl_v,
    input  logic                i_fl_r,
    output logic [W_BITS-1:0]   o_fl_data,
    output logic [IDX_W-1:0]    o_fl_addr,
    output logic                o_if_v,
    input  logic                i_if_r,
    output logic [IFM_DIM-1:0]  o_if_data,
    output logic [IDX_W-1:0]    o_if_addr,
    output logic [TS_W-1:0]     o_if_ts,
    input  logic                i_ld_v,
    output logic                o_ld_r,
    output logic                o_sr_v,
    input  logic                i_sr_r,
    output logic [TS_W-1:0]     o_sr_ts,
    output logic                o_sr_layer,
    input  logic                i_osp_v,
    output logic                o_osp_r,
    input  logic [IDX_W-1:0]    i_osp_addr,
    input  logic [OFM_DIM-1:0]  i_osp_data,
    input  logic                i_dr_v,
    output logic                o_dr_r,
    output logic                o_res_we,
    output logic [ADDR_W-1:0]   o_res_waddr,
    output logic [OFM_DIM-1:0]  o_res_wdata,
    output logic [CNT_W-1:0]    o_spike_cnt
);

    state_t             r_state;
    logic [TS_W-1:0]    r_ts;
    logic [IDX_W-1:0]   r_idx;
    logic               r_rd_wait;   // second cycle of a ROM read
    logic               r_layer;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic               r_ls_v;
    logic               r_ld_r;
    logic               r_osp_r;
    logic [IDX_W-1:0]   r_flt_raddr;
    logic [ADDR_W-1:0]  r_ifm_raddr;

    logic               w_fl_v, w_if_v, w_sr_v;
    logic [FL_PKT_W-1:0] w_fl_pkt;
    logic [IF_PKT_W-1:0] w_if_pkt;
    logic [SR_PKT_W-1:0] w_sr_pkt;
    logic               w_fl_load, w_if_load, w_sr_load;
    logic               w_fl_acc, w_if_acc, w_sr_acc, w_ld_acc, w_ls_acc;
    logic               w_osp_acc, w_osp_in, w_res_we, w_dr_r, w_dr_acc;
    logic               w_last_ts, w_last_idx;

    assign w_fl_load  = (r_state == S_FLT_RD) && r_rd_wait;
    assign w_if_load  = (r_state == S_IFM_RD) && r_rd_wait;
    assign w_sr_load  = (r_state == S_WLD) && r_ld_r && i_ld_v;
    assign w_ls_acc   = r_ls_v && i_ls_r;
    assign w_fl_acc   = w_fl_v && i_fl_r;
    assign w_if_acc   = w_if_v && i_if_r;
    assign w_sr_acc   = w_sr_v && i_sr_r;
    assign w_ld_acc   = w_sr_load;
    assign w_osp_acc  = r_osp_r && i_osp_v;
    assign w_osp_in   = i_osp_addr < IDX_W'(OFM_DIM);
    assign w_res_we   = w_osp_acc && w_osp_in;
    // done_r is held off while a spike row is offered so rows always land first
    assign w_dr_r     = r_osp_r && !i_osp_v;
    assign w_dr_acc   = w_dr_r && i_dr_v;
    assign w_last_ts  = (r_ts == TS_W'(NUM_TS - 1));
    assign w_last_idx = (r_idx == IDX_W'(FLT_N - 1));

    snn_vr_hold #(.WIDTH(FL_PKT_W)) u_fl_hold (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_fl_load),
        .i_data  ({r_idx, i_flt_rdata}),
        .i_ready (i_fl_r),
        .o_valid (w_fl_v),
        .o_data  (w_fl_pkt)
    );

    snn_vr_hold #(.WIDTH(IF_PKT_W)) u_if_hold (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_if_load),
        .i_data  ({r_ts, r_idx, i_ifm_rdata}),
        .i_ready (i_if_r),
        .o_valid (w_if_v),
        .o_data  (w_if_pkt)
    );

    snn_vr_hold #(.WIDTH(SR_PKT_W)) u_sr_hold (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_sr_load),
        .i_data  ({r_ts, r_layer}),
        .i_ready (i_sr_r),
        .o_valid (w_sr_v),
        .o_data  (w_sr_pkt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ts        <= '0;
            r_idx       <= '0;
            r_rd_wait   <= 1'b0;
            r_layer     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_ls_v      <= 1'b0;
            r_ld_r      <= 1'b0;
            r_osp_r     <= 1'b0;
            r_flt_raddr <= '0;
            r_ifm_raddr <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_osp_acc && !w_osp_in) begin
                r_err <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_layer     <= i_layer;
                        r_ts        <= '0;
                        r_idx       <= '0;
                        r_busy      <= 1'b1;
                        r_ls_v      <= 1'b1;
                        r_flt_raddr <= '0;
                        r_state     <= S_LDST;
                    end
                end
                S_LDST: begin
                    if (w_ls_acc) begin
                        r_ls_v    <= 1'b0;
                        r_rd_wait <= 1'b0;
                        r_state   <= S_FLT_RD;
                    end
                end
                S_FLT_RD: begin
                    r_rd_wait <= !r_rd_wait;
                    if (r_rd_wait) begin
                        r_state <= S_FLT_TX;
                    end
                end
                S_FLT_TX: begin
                    if (w_fl_acc) begin
                        if (w_last_idx) begin
                            r_idx       <= '0;
                            r_ifm_raddr <= ifm_addr(r_ts, '0);
                            r_state     <= S_IFM_RD;
                        end else begin
                            r_idx       <= r_idx + 1'b1;
                            r_flt_raddr <= r_idx + 1'b1;
                            r_state     <= S_FLT_RD;
                        end
                    end
                end
                S_IFM_RD: begin
                    r_rd_wait <= !r_rd_wait;
                    if (r_rd_wait) begin
                        r_state <= S_IFM_TX;
                    end
                end
                S_IFM_TX: begin
                    if (w_if_acc) begin
                        if (w_last_idx) begin
                            r_idx   <= '0;
                            r_ld_r  <= 1'b1;
                            r_state <= S_WLD;
                        end else begin
                            r_idx       <= r_idx + 1'b1;
                            r_ifm_raddr <= ifm_addr(r_ts, r_idx + 1'b1);
                            r_state     <= S_IFM_RD;
                        end
                    end
                end
                S_WLD: begin
                    if (w_ld_acc) begin
                        r_ld_r  <= 1'b0;
                        r_state <= S_SRST;
                    end
                end
                S_SRST: begin
                    if (w_sr_acc) begin
                        r_osp_r <= 1'b1;
                        r_state <= S_COLL;
                    end
                end
                S_COLL: begin
                    if (w_dr_acc) begin
                        r_osp_r <= 1'b0;
                        if (w_last_ts) begin
                            r_state <= S_DONE;
                        end else begin
                            r_ts        <= r_ts + 1'b1;
                            r_ifm_raddr <= ifm_addr(r_ts + 1'b1, '0);
                            r_rd_wait   <= 1'b0;
                            r_state     <= S_IFM_RD;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef SNN_SPIKE_COUNT_EN
    logic [CNT_W-1:0] r_spike_cnt;
    logic [CNT_W:0]   w_spike_sum;

    assign w_spike_sum = {1'b0, r_spike_cnt} + (CNT_W + 1)'(popcount(i_osp_data));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_spike_cnt <= '0;
        end else if ((r_state == S_IDLE) && i_start) begin
            r_spike_cnt <= '0;
        end else if (w_res_we) begin
            r_spike_cnt <= w_spike_sum[CNT_W] ? {CNT_W{1'b1}} : w_spike_sum[CNT_W-1:0];
        end
    end

    assign o_spike_cnt = r_spike_cnt;
`else
    assign o_spike_cnt = '0;
`endif

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_flt_raddr = r_flt_raddr;
    assign o_ifm_raddr = r_ifm_raddr;
    assign o_ls_v      = r_ls_v;
    assign o_fl_v      = w_fl_v;
    assign o_fl_addr   = w_fl_pkt[FL_PKT_W-1 -: IDX_W];
    assign o_fl_data   = w_fl_pkt[W_BITS-1:0];
    assign o_if_v      = w_if_v;
    assign o_if_ts     = w_if_pkt[IF_PKT_W-1 -: TS_W];
    assign o_if_addr   = w_if_pkt[IFM_DIM +: IDX_W];
    assign o_if_data   = w_if_pkt[IFM_DIM-1:0];
    assign o_ld_r      = r_ld_r;
    assign o_sr_v      = w_sr_v;
    assign o_sr_ts     = w_sr_pkt[SR_PKT_W-1 -: TS_W];
    assign o_sr_layer  = w_sr_pkt[0];
    assign o_osp_r     = r_osp_r;
    assign o_dr_r      = w_dr_r;
    // write port is zeroed outside a write so the RAM sees clean idle values
    assign o_res_we    = w_res_we;
    assign o_res_waddr = w_res_we ? res_addr(r_ts, i_osp_addr) : '0;
    assign o_res_wdata = w_res_we ? i_osp_data : '0;

endmodule
`default_nettype wire

// File: tb/tb_snn_host_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_snn_host_sequencer
// Purpose  : Directed self-checking bench for snn_host_sequencer (NUM_TS=2).
//            A NoC agent answers every stream and checks each transfer against
//            the bench's ROM images and hand-written spike-row vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snn_host_sequencer;

    localparam int NTS = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start, i_layer;
    logic        o_busy, o_done, o_err;
    logic [4:0]  o_flt_raddr;
    logic [7:0]  i_flt_rdata;
    logic [7:0]  o_ifm_raddr;
    logic [24:0] i_ifm_rdata;
    logic        o_ls_v, i_ls_r;
    logic        o_fl_v, i_fl_r;
    logic [7:0]  o_fl_data;
    logic [4:0]  o_fl_addr;
    logic        o_if_v, i_if_r;
    logic [24:0] o_if_data;
    logic [4:0]  o_if_addr;
    logic [3:0]  o_if_ts;
    logic        i_ld_v, o_ld_r;
    logic        o_sr_v, i_sr_r;
    logic [3:0]  o_sr_ts;
    logic        o_sr_layer;
    logic        i_osp_v, o_osp_r;
    logic [4:0]  i_osp_addr;
    logic [20:0] i_osp_data;
    logic        i_dr_v, o_dr_r;
    logic        o_res_we;
    logic [7:0]  o_res_waddr;
    logic [20:0] o_res_wdata;
    logic [15:0] o_spike_cnt;

    snn_host_sequencer #(.NUM_TS(NTS)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_layer(i_layer),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
        .o_flt_raddr(o_flt_raddr), .i_flt_rdata(i_flt_rdata),
        .o_ifm_raddr(o_ifm_raddr), .i_ifm_rdata(i_ifm_rdata),
        .o_ls_v(o_ls_v), .i_ls_r(i_ls_r),
        .o_fl_v(o_fl_v), .i_fl_r(i_fl_r), .o_fl_data(o_fl_data), .o_fl_addr(o_fl_addr),
        .o_if_v(o_if_v), .i_if_r(i_if_r), .o_if_data(o_if_data), .o_if_addr(o_if_addr),
        .o_if_ts(o_if_ts),
        .i_ld_v(i_ld_v), .o_ld_r(o_ld_r),
        .o_sr_v(o_sr_v), .i_sr_r(i_sr_r), .o_sr_ts(o_sr_ts), .o_sr_layer(o_sr_layer),
        .i_osp_v(i_osp_v), .o_osp_r(o_osp_r), .i_osp_addr(i_osp_addr), .i_osp_data(i_osp_data),
        .i_dr_v(i_dr_v), .o_dr_r(o_dr_r),
        .o_res_we(o_res_we), .o_res_waddr(o_res_waddr), .o_res_wdata(o_res_wdata),
        .o_spike_cnt(o_spike_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- ROM images (1-cycle read latency) ----------------
    logic [7:0]  flt_rom [0:31];
    logic [24:0] ifm_rom [0:255];

    initial begin
        for (int i = 0; i < 32; i++) flt_rom[i] = 8'(i * 7 + 3);
        for (int i = 0; i < 256; i++) begin
            logic [31:0] t;
            t = i * 32'h0002_468B + 32'h0001_3579;
            ifm_rom[i] = t[24:0];
        end
    end

    always @(posedge clk) begin
        i_flt_rdata <= flt_rom[o_flt_raddr];
        i_ifm_rdata <= ifm_rom[o_ifm_raddr];
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- spike row vectors ----------------
    typedef struct {
        logic [3:0]  ts;
        logic [4:0]  addr;
        logic [20:0] data;
        logic        we;
        logic [7:0]  waddr;
    } row_t;

    row_t rowq[$];

    // ---------------- agent state ----------------
    bit   stall_en  = 1'b0;
    logic exp_layer = 1'b0;
    int ls_cnt, fl_cnt, if_row, if_ts_exp, if_tot, sr_cnt, ld_cnt, dr_cnt, wr_cnt;
    bit   pend_fl, pend_if;
    logic [12:0] sav_fl;
    logic [33:0] sav_if;

    task automatic clear_counts();
        ls_cnt = 0; fl_cnt = 0; if_row = 0; if_ts_exp = 0; if_tot = 0;
        sr_cnt = 0; ld_cnt = 0; dr_cnt = 0; wr_cnt = 0;
        pend_fl = 1'b0; pend_if = 1'b0;
    endtask

    function automatic logic rdy();
        return stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    endfunction

    // Drives ready/valid inputs on the falling edge, then samples the
    // handshakes that the next rising edge will complete.
    initial begin
        i_ls_r = 0; i_fl_r = 0; i_if_r = 0; i_sr_r = 0; i_ld_v = 0; i_dr_v = 0;
        i_osp_v = 0; i_osp_addr = 0; i_osp_data = 0;
        forever begin
            @(negedge clk);
            i_ls_r = rdy(); i_fl_r = rdy(); i_if_r = rdy(); i_sr_r = rdy();
            i_ld_v = 1'b1;
            i_dr_v = 1'b1;
            if (rowq.size() > 0 && o_busy && rowq[0].ts == o_if_ts) begin
                i_osp_v = 1'b1; i_osp_addr = rowq[0].addr; i_osp_data = rowq[0].data;
            end else begin
                i_osp_v = 1'b0; i_osp_addr = '0; i_osp_data = '0;
            end
            #1;
            if (rst) begin
                pend_fl = 1'b0; pend_if = 1'b0;
            end else begin
                if (pend_fl) check_eq("fl_hold", {o_fl_v, o_fl_addr, o_fl_data}, {1'b1, sav_fl});
                if (pend_if) check_eq("if_hold", {o_if_v, o_if_ts, o_if_addr, o_if_data}, {1'b1, sav_if});
                pend_fl = o_fl_v && !i_fl_r;
                pend_if = o_if_v && !i_if_r;
                sav_fl  = {o_fl_addr, o_fl_data};
                sav_if  = {o_if_ts, o_if_addr, o_if_data};

                if (o_ls_v && i_ls_r) ls_cnt++;
                if (o_fl_v && i_fl_r) begin
                    check_eq("fl_addr", o_fl_addr, fl_cnt);
                    check_eq("fl_data", o_fl_data, flt_rom[fl_cnt]);
                    fl_cnt++;
                end
                if (o_if_v && i_if_r) begin
                    check_eq("if_addr", o_if_addr, if_row);
                    check_eq("if_ts", o_if_ts, if_ts_exp);
                    check_eq("if_data", o_if_data, ifm_rom[if_ts_exp * 25 + if_row]);
                    if_tot++;
                    if_row++;
                    if (if_row == 25) begin
                        if_row = 0;
                        if_ts_exp++;
                    end
                end
                if (i_ld_v && o_ld_r) ld_cnt++;
                if (o_sr_v && i_sr_r) begin
                    check_eq("sr_ts", o_sr_ts, sr_cnt);
                    check_eq("sr_layer", o_sr_layer, exp_layer);
                    sr_cnt++;
                end
                if (o_res_we && !(i_osp_v && o_osp_r)) check_eq("res_we_stray", o_res_we, 0);
                if (i_osp_v && o_osp_r) begin
                    check_eq("res_we", o_res_we, rowq[0].we);
                    if (rowq[0].we) begin
                        check_eq("res_waddr", o_res_waddr, rowq[0].waddr);
                        check_eq("res_wdata", o_res_wdata, rowq[0].data);
                        wr_cnt++;
                    end
                    void'(rowq.pop_front());
                end
                if (i_dr_v && o_dr_r) begin
                    check_eq("dr_while_osp", i_osp_v, 0);
                    dr_cnt++;
                end
            end
        end
    end

    // ---------------- sequence helpers ----------------
    task automatic start_run(input logic layer);
        @(negedge clk);
        i_start = 1'b1; i_layer = layer;
        @(negedge clk);
        i_start = 1'b0; i_layer = 1'b0;
        check_eq("busy_after_start", o_busy, 1);
    endtask

    task automatic wait_done(input int max_cycles);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < max_cycles && !seen; c++) begin
            @(negedge clk);
            if (o_done) seen = 1'b1;
        end
        check_eq("done_seen", seen, 1);
        if (seen) check_eq("busy_at_done", o_busy, 0);
        @(negedge clk);
        check_eq("done_pulse_1cyc", o_done, 0);
    endtask

    task automatic check_run_counts(input int exp_wr);
        check_eq("ls_cnt", ls_cnt, 1);
        check_eq("fl_cnt", fl_cnt, 25);
        check_eq("if_tot", if_tot, 25 * NTS);
        check_eq("ld_cnt", ld_cnt, NTS);
        check_eq("sr_cnt", sr_cnt, NTS);
        check_eq("dr_cnt", dr_cnt, NTS);
        check_eq("wr_cnt", wr_cnt, exp_wr);
        check_eq("rows_left", rowq.size(), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [15:0] exp_cnt;
        bit found;
        rst = 1'b1; i_start = 1'b0; i_layer = 1'b0;
        clear_counts();
        repeat (3) @(negedge clk);
        check_eq("rst_busy", o_busy, 0);
        check_eq("rst_done", o_done, 0);
        check_eq("rst_err", o_err, 0);
        check_eq("rst_valids", {o_ls_v, o_fl_v, o_if_v, o_sr_v}, 0);
        check_eq("rst_readies", {o_ld_r, o_osp_r, o_dr_r, o_res_we}, 0);
        check_eq("rst_data", {o_fl_data, o_if_data, o_sr_ts, o_res_waddr}, 0);
        check_eq("rst_spike_cnt", o_spike_cnt, 0);
        @(negedge clk);
        rst = 1'b0;

        // Run 1: ready always high, two rows in ts 1 offered together with done_r
        exp_layer = 1'b1;
        rowq.push_back('{ts: 4'd1, addr: 5'd3,  data: 21'h1F, we: 1'b1, waddr: 8'd24});
        rowq.push_back('{ts: 4'd1, addr: 5'd20, data: 21'h01, we: 1'b1, waddr: 8'd41});
        start_run(1'b1);
        repeat (20) @(negedge clk);
        i_start = 1'b1; i_layer = 1'b0;   // ignored while busy
        @(negedge clk);
        i_start = 1'b0;
        wait_done(3000);
        check_run_counts(2);
`ifdef SNN_SPIKE_COUNT_EN
        exp_cnt = 16'd6;
`else
        exp_cnt = 16'd0;
`endif
        check_eq("spike_cnt_run1", o_spike_cnt, exp_cnt);
        check_eq("err_run1", o_err, 0);

        // Run 2: random stalls, one out-of-range row in ts 0
        clear_counts();
        stall_en  = 1'b1;
        exp_layer = 1'b0;
        rowq.push_back('{ts: 4'd0, addr: 5'd21, data: 21'h5, we: 1'b0, waddr: 8'd0});
        start_run(1'b0);
        wait_done(6000);
        check_run_counts(0);
        check_eq("spike_cnt_run2", o_spike_cnt, 0);
        check_eq("err_set", o_err, 1);
        repeat (5) @(negedge clk);
        check_eq("err_sticky", o_err, 1);

        // Run 3: reset while ifmap row 12 of ts 0 is offered, then replay
        clear_counts();
        stall_en  = 1'b0;
        exp_layer = 1'b1;
        start_run(1'b1);
        found = 1'b0;
        for (int c = 0; c < 2000 && !found; c++) begin
            @(negedge clk);
            if (o_if_v && o_if_addr == 5'd12) found = 1'b1;
        end
        check_eq("if_row12_seen", found, 1);
        rst = 1'b1;
        #1;
        check_eq("midrst_valids", {o_ls_v, o_fl_v, o_if_v, o_sr_v}, 0);
        check_eq("midrst_busy", o_busy, 0);
        check_eq("midrst_err_clear", o_err, 0);
        @(negedge clk);
        rst = 1'b0;
        clear_counts();
        start_run(1'b1);
        wait_done(3000);
        check_run_counts(0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
